sram_upload: RTL and testbench

Streams a contiguous byte range out of the shared 8-bit SRAM to the host-side upload channel. It is the read-back counterpart of the ioctl download path that fills SRAM. While active it owns the SRAM address bus; the top level muxes `sram_a` over the video fetch address whenever `busy` is high. Bytes are read ahead into a 2-entry FIFO and presented on a valid/ready stream, each tagged with its offset from the start of the range.

---
 rtl/sram_upload.sv | 173 +++++++++++++++++
 tb/tb_sram_upload.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_upload.sv
// sram_upload
//
// Streams a contiguous byte range out of the shared 8-bit SRAM onto a
// valid/ready upload stream. This is the read-back partner of the download
// path that fills SRAM. While busy is high this block owns the SRAM address
// bus, and the top level muxes sram_a over the video fetch address.
//
// Bytes are read ahead into a 2-entry FIFO. Each byte is tagged with its
// offset from the start of the range.
//
// Each read takes 2+WAIT cycles: ADDR, then WAIT cycles in WAITS, then LATCH.
//
// Ports:
//   clock, reset_n        rising-edge clock; asynchronous active-low reset
//   start, base, length   transfer request; base and length are sampled
//                         together with start, and only while idle
//   abort                 cancels a running transfer; no done is produced
//   busy                  transfer in progress; the SRAM bus is owned
//   done                  one-cycle pulse at normal completion
//   sram_a, sram_rd       SRAM read address, and its qualifier
//   sram_d                SRAM read data
//   out_valid, out_ready  stream handshake; a byte moves when both are high
//   out_data, out_addr    head byte and its offset from base
module sram_upload #(
   parameter int AW   = 16,
   parameter int WAIT = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   length,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] sram_a,
   output logic          sram_rd,
   input  logic [7:0]    sram_d,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic [AW-1:0] out_addr
);

   // HOLD is LATCH with no capture: the last byte landed in a full FIFO,
   // so the next read waits until a slot frees.
   typedef enum logic [2:0] {IDLE, ADDR, WAITS, LATCH, HOLD} state_t;

   localparam logic [2:0] WAIT_M1  = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
   localparam logic [AW:0] LEFT_ONE = (AW+1)'(1);

   state_t          state, stateNext;
   logic            busyR, doneR;
   logic [AW-1:0]   rdPtr;
   logic [AW:0]     rdLeft;
   logic [AW:0]     txLeft;
   logic [AW-1:0]   ofs;
   logic [2:0]      waitCnt;
   logic [1:0]      fifoCnt;
   logic [7:0]      headData, tailData;
   logic [AW-1:0]   headAddr, tailAddr;

   logic            take, kill, startRun, startZero;
   logic            push, pop, lastPop, slotFree;
   logic [1:0]      cntAfter;

   // A start request is taken only in IDLE with no drain pending.
   // An abort has effect only while busy.
   assign take      = (state == IDLE) && !busyR && start;
   assign kill      = abort && busyR;
   assign startRun  = take && (length != '0);
   assign startZero = take && (length == '0);

   assign push      = (state == LATCH) && !kill;
   assign pop       = (fifoCnt != 2'd0) && out_ready && !kill;
   assign lastPop   = pop && (txLeft == LEFT_ONE);

   // FIFO occupancy after this edge. Using this value lets a pop in the
   // same cycle free a slot for the next read.
   assign cntAfter  = fifoCnt + 2'(push) - 2'(pop);
   assign slotFree  = cntAfter < 2'd2;

   assign busy      = busyR;
   assign done      = doneR;
   assign sram_a    = rdPtr;
   assign sram_rd   = (state == ADDR) || (state == WAITS) || (state == LATCH);
   assign out_valid = fifoCnt != 2'd0;
   assign out_data  = headData;
   assign out_addr  = headAddr;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startRun) stateNext = ADDR;
         ADDR:    stateNext = (WAIT > 0) ? WAITS : LATCH;
         WAITS:   if (waitCnt == 3'd0) stateNext = LATCH;
         LATCH: begin
            if (rdLeft == LEFT_ONE) stateNext = IDLE;   // drain: busy stays high
            else if (slotFree)      stateNext = ADDR;
            else                    stateNext = HOLD;
         end
         HOLD:    if (slotFree) stateNext = ADDR;
         default: stateNext = IDLE;
      endcase
      if (kill) stateNext = IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busyR    <= 1'b0;
         doneR    <= 1'b0;
         rdPtr    <= '0;
         rdLeft   <= '0;
         txLeft   <= '0;
         ofs      <= '0;
         waitCnt  <= 3'd0;
         fifoCnt  <= 2'd0;
         headData <= 8'd0;
         headAddr <= '0;
      end else begin
         state <= stateNext;
         doneR <= startZero || lastPop;

         if (kill)          busyR <= 1'b0;
         else if (startRun) busyR <= 1'b1;
         else if (lastPop)  busyR <= 1'b0;

         if (startRun) begin
            rdPtr  <= base;
            rdLeft <= length;
            txLeft <= length;
            ofs    <= '0;
         end else begin
            if (push) begin
               rdPtr  <= rdPtr + AW'(1);        // wraps to 0 at the top of SRAM
               rdLeft <= rdLeft - LEFT_ONE;
               ofs    <= ofs + AW'(1);
            end
            if (pop) txLeft <= txLeft - LEFT_ONE;
         end

         if (state == ADDR)       waitCnt <= WAIT_M1;
         else if (state == WAITS) waitCnt <= waitCnt - 3'd1;

         if (kill) fifoCnt <= 2'd0;
         else      fifoCnt <= cntAfter;

         // The head is the visible output register. It changes only on a pop
         // or on a push into an empty FIFO, so it holds still under
         // backpressure.
         if (!kill) begin
            if (pop && fifoCnt == 2'd2) begin
               headData <= tailData;
               headAddr <= tailAddr;
            end else if (push && (fifoCnt == 2'd0 || (pop && fifoCnt == 2'd1))) begin
               headData <= sram_d;
               headAddr <= ofs;
            end
         end
      end
   end

   // The second entry is pure data that is only read when fifoCnt says it
   // is occupied, so it has no reset.
   always_ff @(posedge clock) begin
      if (push && cntAfter == 2'd2) begin
         tailData <= sram_d;
         tailAddr <= ofs;
      end
   end

endmodule

// File: tb/tb_sram_upload.sv
module tb_sram_upload;
   localparam int AW = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Main instance (WAIT=2).
   logic          resetN, start, abort, outReady;
   logic [AW-1:0] base;
   logic [AW:0]   length;
   logic          busy, done, sramRd, outValid;
   logic [AW-1:0] sramA, outAddr;
   logic [7:0]    sramD, outData;
   assign sramD = sramA[7:0];

   sram_upload #(.AW(AW), .WAIT(2)) dut (
      .clock(clock), .reset_n(resetN), .start(start), .abort(abort),
      .base(base), .length(length), .busy(busy), .done(done),
      .sram_a(sramA), .sram_rd(sramRd), .sram_d(sramD),
      .out_valid(outValid), .out_ready(outReady),
      .out_data(outData), .out_addr(outAddr));

   // Second instance (WAIT=0) for the asynchronous reset scenario.
   logic          resetBN, startB, abortB, readyB;
   logic [AW-1:0] baseB;
   logic [AW:0]   lengthB;
   logic          busyB, doneB, sramRdB, outValidB;
   logic [AW-1:0] sramAB, outAddrB;
   logic [7:0]    sramDB, outDataB;
   assign sramDB = sramAB[7:0];

   sram_upload #(.AW(AW), .WAIT(0)) dutB (
      .clock(clock), .reset_n(resetBN), .start(startB), .abort(abortB),
      .base(baseB), .length(lengthB), .busy(busyB), .done(doneB),
      .sram_a(sramAB), .sram_rd(sramRdB), .sram_d(sramDB),
      .out_valid(outValidB), .out_ready(readyB),
      .out_data(outDataB), .out_addr(outAddrB));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   typedef struct packed { logic [7:0] d; logic [15:0] a; } ent_t;
   ent_t        expQ[$];
   ent_t        gotQ[$];
   logic [15:0] readLog[$];
   bit          mActive = 1'b0;
   bit          mDone   = 1'b0;
   bit          modelOn = 1'b0;

   // Transaction-level model of the main instance. A start with non-zero
   // length queues every byte of the range: the byte is the low address
   // byte and the tag is the offset. Accepted handshakes consume the queue
   // in order. The transfer ends (with a done pulse) when the queue empties.
   // An abort discards the queue and produces no done.
   initial begin : compare
      bit          prevRd;
      logic [15:0] prevA;
      ent_t        e;
      prevRd = 1'b0;
      prevA  = '0;
      forever begin
         @(negedge clock);
         if (modelOn) begin
            chk("busy", busy, mActive);
            chk("done", done, mDone);
            if (outValid) begin
               if (expQ.size() == 0) chk("unexpected_valid", outValid, 0);
               else begin
                  chk("out_data", outData, expQ[0].d);
                  chk("out_addr", outAddr, expQ[0].a);
               end
            end
            if (!mActive) chk("valid_when_idle", outValid, 0);

            if (sramRd && (!prevRd || sramA != prevA)) readLog.push_back(sramA);
            prevRd = sramRd;
            prevA  = sramA;

            mDone = 1'b0;
            if (!resetN) begin
               mActive = 1'b0;
               expQ.delete();
            end else if (mActive && abort) begin
               mActive = 1'b0;
               expQ.delete();
            end else if (!mActive && start) begin
               if (length == '0) mDone = 1'b1;
               else begin
                  mActive = 1'b1;
                  for (int i = 0; i < int'(length); i++) begin
                     e.d = 8'(base + 16'(i));
                     e.a = 16'(i);
                     expQ.push_back(e);
                  end
               end
            end else if (mActive && outValid && outReady && expQ.size() != 0) begin
               e.d = outData;
               e.a = outAddr;
               gotQ.push_back(e);
               void'(expQ.pop_front());
               if (expQ.size() == 0) begin
                  mActive = 1'b0;
                  mDone   = 1'b1;
               end
            end
         end
      end
   end

   task automatic doStart(input logic [15:0] b, input logic [16:0] l);
      @(posedge clock); #1;
      base = b; length = l; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic waitValid(input string nm, output int n);
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!outValid && n < 60);
      if (!outValid) chk({nm, "_timeout"}, outValid, 1);
   endtask

   task automatic waitDone(input string nm, output int n);
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!done && n < 2000);
      if (!done) chk({nm, "_timeout"}, done, 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int n;
      logic [15:0] wrapA [4];
      logic [7:0]  wrapD [4];
      wrapA = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      wrapD = '{8'hFE, 8'hFF, 8'h00, 8'h01};

      resetN = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b0;
      base = '0; length = '0;
      resetBN = 1'b0; startB = 1'b0; abortB = 1'b0; readyB = 1'b0;
      baseB = '0; lengthB = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sram_rd", sramRd, 0);
      chk("rst_sram_a", sramA, 0);
      chk("rst_out_valid", outValid, 0);
      chk("rst_out_data", outData, 0);
      chk("rst_out_addr", outAddr, 0);
      resetN = 1'b1; resetBN = 1'b1; modelOn = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Basic transfer: latency 4, spacing 4, done one cycle after last accept.
      outReady = 1'b1;
      gotQ.delete(); readLog.delete();
      doStart(16'h1234, 17'd3);
      chk("t1_busy_after_start", busy, 1);
      chk("t1_sram_a_first", sramA, 16'h1234);
      chk("t1_sram_rd_first", sramRd, 1);
      waitValid("t1_v0", n); chk("t1_first_latency", n, 4);
      waitValid("t1_v1", n); chk("t1_spacing1", n, 4);
      waitValid("t1_v2", n); chk("t1_spacing2", n, 4);
      waitDone("t1_done", n); chk("t1_done_delay", n, 1);
      chk("t1_busy_at_done", busy, 0);
      @(posedge clock); #1;
      chk("t1_done_one_cycle", done, 0);
      chk("t1_count", gotQ.size(), 3);
      if (gotQ.size() == 3) begin
         chk("t1_b0", {gotQ[0].d, gotQ[0].a}, {8'h34, 16'd0});
         chk("t1_b1", {gotQ[1].d, gotQ[1].a}, {8'h35, 16'd1});
         chk("t1_b2", {gotQ[2].d, gotQ[2].a}, {8'h36, 16'd2});
      end

      // Backpressure: only two reads may be issued while the consumer stalls.
      outReady = 1'b0;
      gotQ.delete(); readLog.delete();
      doStart(16'h0100, 17'd5);
      repeat (30) @(posedge clock);
      #1;
      chk("t2_reads_stalled", readLog.size(), 2);
      chk("t2_sram_rd_low", sramRd, 0);
      chk("t2_valid_held", outValid, 1);
      chk("t2_data_held", outData, 8'h00);
      outReady = 1'b1;
      waitDone("t2_done", n);
      chk("t2_count", gotQ.size(), 5);
      chk("t2_reads_total", readLog.size(), 5);
      for (int i = 0; i < 5 && i < gotQ.size(); i++)
         chk("t2_byte", {gotQ[i].d, gotQ[i].a}, {8'(i), 16'(i)});

      // Address wrap at the top of SRAM.
      gotQ.delete(); readLog.delete();
      doStart(16'hFFFE, 17'd4);
      waitDone("t3_done", n);
      chk("t3_reads", readLog.size(), 4);
      for (int i = 0; i < 4 && i < readLog.size(); i++) chk("t3_sram_a", readLog[i], wrapA[i]);
      chk("t3_count", gotQ.size(), 4);
      for (int i = 0; i < 4 && i < gotQ.size(); i++)
         chk("t3_byte", {gotQ[i].d, gotQ[i].a}, {wrapD[i], 16'(i)});

      // Zero length, then a start pulsed while busy is ignored.
      doStart(16'h0020, 17'd0);
      chk("t4_zero_done", done, 1);
      chk("t4_zero_busy", busy, 0);
      @(posedge clock); #1;
      chk("t4_zero_done_fall", done, 0);
      gotQ.delete();
      doStart(16'h0010, 17'd3);
      @(posedge clock); #1;
      doStart(16'h0200, 17'd5);
      waitDone("t4_done", n);
      repeat (20) @(posedge clock);
      #1;
      chk("t4_count", gotQ.size(), 3);
      for (int i = 0; i < 3 && i < gotQ.size(); i++)
         chk("t4_byte", gotQ[i].d, 8'h10 + 8'(i));

      // Abort after two accepted bytes, then a clean transfer.
      gotQ.delete();
      doStart(16'h0040, 17'd8);
      n = 0;
      while (gotQ.size() < 2 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      chk("t5_two_accepted", gotQ.size(), 2);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_valid", outValid, 0);
      chk("t5_done", done, 0);
      repeat (10) @(posedge clock);
      #1;
      chk("t5_no_more_bytes", gotQ.size(), 2);
      gotQ.delete();
      doStart(16'h0050, 17'd3);
      waitDone("t5_restart_done", n);
      chk("t5_restart_count", gotQ.size(), 3);
      for (int i = 0; i < 3 && i < gotQ.size(); i++)
         chk("t5_restart_byte", {gotQ[i].d, gotQ[i].a}, {8'h50 + 8'(i), 16'(i)});

      // Asynchronous reset mid-transfer on the WAIT=0 instance.
      @(posedge clock); #1;
      baseB = 16'h0345; lengthB = 17'd6; startB = 1'b1;
      @(posedge clock); #1;
      startB = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("t6_busy_pre", busyB, 1);
      chk("t6_valid_pre", outValidB, 1);
      #2;
      resetBN = 1'b0;
      #1;
      chk("t6_rst_busy", busyB, 0);
      chk("t6_rst_done", doneB, 0);
      chk("t6_rst_sram_rd", sramRdB, 0);
      chk("t6_rst_sram_a", sramAB, 0);
      chk("t6_rst_valid", outValidB, 0);
      chk("t6_rst_data", outDataB, 0);
      chk("t6_rst_addr", outAddrB, 0);
      @(posedge clock); #1;
      readyB = 1'b1;
      resetBN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk("t6_idle_busy", busyB, 0);
         chk("t6_idle_valid", outValidB, 0);
         chk("t6_idle_done", doneB, 0);
         chk("t6_idle_rd", sramRdB, 0);
      end
      baseB = 16'h0310; lengthB = 17'd2; startB = 1'b1;
      @(posedge clock); #1;
      startB = 1'b0;
      n = 0;
      do begin @(posedge clock); #1; n++; end while (!outValidB && n < 20);
      chk("t6_latency", n, 2);
      chk("t6_b0", {outDataB, outAddrB}, {8'h10, 16'd0});
      @(posedge clock); #1;
      n = 0;
      do begin @(posedge clock); #1; n++; end while (!outValidB && n < 20);
      chk("t6_b1", {outDataB, outAddrB}, {8'h11, 16'd1});
      @(posedge clock); #1;
      chk("t6_done", doneB, 1);
      chk("t6_busy_end", busyB, 0);

      repeat (3) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
